// File: rtl/booth_seq_ctrl.sv
// Iterative radix-2 Booth multiplier sequencer.
// Takes a signed operand pair, runs WIDTH_IN add/sub+shift steps, and returns the signed product.
module booth_seq_ctrl #(
    parameter int WIDTH_IN = 16,
    parameter int WIDTH_PP = 33
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH_IN-1:0]     in_a,
    input  logic [WIDTH_IN-1:0]     in_b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*WIDTH_IN-1:0]   out_product,
    output logic                    busy
);

    localparam int AW = WIDTH_IN + 1;
    localparam int CW = $clog2(WIDTH_IN) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH_IN - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t              state;
    logic [WIDTH_PP-1:0] pp;
    logic                q_1;
    logic [AW-1:0]       mcand;
    logic [CW-1:0]       count;

    logic [AW-1:0]       acc_a;
    logic [WIDTH_IN-1:0] acc_q;
    logic [AW-1:0]       sum_a;
    logic [AW-1:0]       next_a;
    logic [WIDTH_IN-1:0] next_q;

    // One Booth step: pick add/sub/none from {Q[0], q_1}, then shift {A,Q,q_1} right arithmetically.
    always_comb begin
        acc_a = pp[WIDTH_PP-1 -: AW];
        acc_q = pp[WIDTH_IN-1:0];
        case ({acc_q[0], q_1})
            2'b01:   sum_a = acc_a + mcand;
            2'b10:   sum_a = acc_a - mcand;
            default: sum_a = acc_a;
        endcase
        next_a = {sum_a[AW-1], sum_a[AW-1:1]};
        next_q = {sum_a[0], acc_q[WIDTH_IN-1:1]};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            pp          <= '0;
            q_1         <= 1'b0;
            mcand       <= '0;
            count       <= '0;
            out_product <= '0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        pp       <= {{AW{1'b0}}, in_b};
                        q_1      <= 1'b0;
                        mcand    <= {in_a[WIDTH_IN-1], in_a};
                        count    <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    pp    <= {next_a, next_q};
                    q_1   <= acc_q[0];
                    count <= count + 1'b1;
                    // The product is the low WIDTH_IN bits of A plus Q; A's extra bit only guards overflow.
                    if (count == LAST_STEP) begin
                        out_product <= {next_a[WIDTH_IN-1:0], next_q};
                        out_valid   <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Directed self-checking bench for booth_seq_ctrl: vector table, stall, mid-operation reset
// and a back-to-back random stream.
module tb_booth_seq_ctrl;

    localparam int W = 16;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   in_a = '0;
    logic [W-1:0]   in_b = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [2*W-1:0] out_product;
    logic           busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    booth_seq_ctrl #(.WIDTH_IN(W), .WIDTH_PP(2*W+1)) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_a(in_a),
        .in_b(in_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_product(out_product),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Present operands, wait for acceptance, then wait (bounded) for out_valid.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input bit keep_valid,
                                 output logic [2*W-1:0] prod, output int lat, output int acc_cyc);
        int n;
        @(negedge clk);
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) checkOutput("accept_timeout", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        if (!keep_valid) in_valid = 1'b0;
        in_a = ~a;
        in_b = ~b;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid) break;
        end
        prod = out_product;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [2*W-1:0] prod;
        logic [2*W-1:0] exp;
        int lat;
        int acc;
        int prev_acc;

        vecs[0]  = '{16'h0003, 16'h0005, 32'h0000000F};
        vecs[1]  = '{16'hFFFD, 16'h0005, 32'hFFFFFFF1};
        vecs[2]  = '{16'h0005, 16'hFFFD, 32'hFFFFFFF1};
        vecs[3]  = '{16'hFFFD, 16'hFFFB, 32'h0000000F};
        vecs[4]  = '{16'h8000, 16'h8000, 32'h40000000};
        vecs[5]  = '{16'h7FFF, 16'h8000, 32'hC0008000};
        vecs[6]  = '{16'h8000, 16'h0001, 32'hFFFF8000};
        vecs[7]  = '{16'h0000, 16'hFFFF, 32'h00000000};
        vecs[8]  = '{16'hFFFF, 16'hFFFF, 32'h00000001};
        vecs[9]  = '{16'hFFFF, 16'h0000, 32'h00000000};
        vecs[10] = '{16'h7FFF, 16'h7FFF, 32'h3FFF0001};
        vecs[11] = '{16'hFFFF, 16'h7FFF, 32'hFFFF8001};

        #12;
        checkOutput("reset_in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("reset_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("reset_busy", {31'b0, busy}, 32'd0);
        checkOutput("reset_product", out_product, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, 1'b0, prod, lat, acc);
            checkOutput($sformatf("vec%0d_product", i), prod, vecs[i].exp);
            checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'd16);
        end

        // Stalled consumer: result must hold and new operands must be ignored.
        @(negedge clk);
        out_ready = 1'b0;
        applyStimulus(16'd123, 16'hFFD3, 1'b0, prod, lat, acc);
        checkOutput("stall_product", prod, 32'hFFFFEA61);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_a = 16'd1;
            in_b = 16'd1;
            @(negedge clk);
            checkOutput($sformatf("stall%0d_out_valid", i), {31'b0, out_valid}, 32'd1);
            checkOutput($sformatf("stall%0d_in_ready", i), {31'b0, in_ready}, 32'd0);
            checkOutput($sformatf("stall%0d_product", i), out_product, 32'hFFFFEA61);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("release_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("release_in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("release_busy", {31'b0, busy}, 32'd0);
        checkOutput("release_product_hold", out_product, 32'hFFFFEA61);

        // Abort an operation part-way through CALC with reset.
        @(negedge clk);
        in_a = 16'd100;
        in_b = 16'd100;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        checkOutput("calc_busy", {31'b0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        checkOutput("abort_in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("abort_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("abort_busy", {31'b0, busy}, 32'd0);
        checkOutput("abort_product", out_product, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) checkOutput("abort_spurious_valid", {31'b0, out_valid}, 32'd0);
        end
        applyStimulus(16'd7, 16'hFFF7, 1'b0, prod, lat, acc);
        checkOutput("post_abort_product", prod, 32'hFFFFFFC1);
        checkOutput("post_abort_latency", 32'(lat), 32'd16);

        // Back-to-back random stream with in_valid held high throughout.
        prev_acc = 0;
        for (int i = 0; i < 100; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = 16'($urandom);
            rb = 16'($urandom);
            exp = 32'(int'($signed(ra)) * int'($signed(rb)));
            applyStimulus(ra, rb, 1'b1, prod, lat, acc);
            checkOutput($sformatf("rand%0d_product", i), prod, exp);
            if (i > 0) checkOutput($sformatf("rand%0d_spacing", i), 32'(acc - prev_acc), 32'd18);
            prev_acc = acc;
        end
        in_valid = 1'b0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
